rx_start_detect: RTL and testbench

Parametrised UART receiver start-bit detector. It replaces the combinational level check with a synchronised, oversampled and validated detector. It sits between the raw `rx_in` pin and the receiver's bit-sampling FSM, and issues a single-cycle `start_valid` pulse only when a low level persists to mid-bit. Glitches are rejected and counted, and the detector re-arms only after the line has returned to idle.

---
 rtl/rx_start_detect.sv | 165 ++++++++++++++++
 tb/tb_rx_start_detect.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_start_detect.sv
// UART start-bit detector: synchronises rx_in, arms after an idle run, validates a low level at mid-bit.
// Optional build macro RX_START_MAJORITY_EN selects a 2-of-3 mid-bit vote instead of a single mid sample.
module rx_start_detect #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int ARM_TICKS   = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_in,
  input  logic             baud_tick,
  input  logic             frame_busy,
  input  logic             clr_count,
  output logic             start_valid,
  output logic             false_start,
  output logic             detecting,
  output logic             armed,
  output logic [CNT_W-1:0] false_count
);

  typedef enum logic [1:0] {IDLE_WAIT, ARMED, CHECK} state_e;

  localparam int M  = OVERSAMPLE / 2;
  localparam int BW = $clog2(OVERSAMPLE) + 1;
  localparam int IW = $clog2(ARM_TICKS + 1);

  localparam logic [BW-1:0]    BIT_ONE  = BW'(1);
  localparam logic [BW-1:0]    S_MID    = BW'(M);
  localparam logic [BW-1:0]    S_HI     = BW'(M + 1);
  localparam logic [IW-1:0]    IDLE_ONE = IW'(1);
  localparam logic [IW-1:0]    ARM_LAST = IW'(ARM_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  state_e                 state_q;
  logic [IW-1:0]          idle_cnt_q;
  logic [BW-1:0]          bit_cnt_q;
  logic [BW-1:0]          bit_cnt_d;
  logic                   start_valid_q;
  logic                   false_start_q;
  logic [CNT_W-1:0]       false_count_q;
  logic                   sample_en;
  logic                   line_low;

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Tick index this cycle would carry: the first low tick seen while armed is tick 1.
  assign bit_cnt_d = (state_q == ARMED) ? BIT_ONE : bit_cnt_q + BIT_ONE;

  assign sample_en = baud_tick && !frame_busy &&
                     ((state_q == CHECK) || ((state_q == ARMED) && !rx_s));

`ifdef RX_START_MAJORITY_EN
  localparam logic [BW-1:0] S_LO = BW'(M - 1);
  logic [1:0] samp_q;  // [1] = sample at M-1, [0] = sample at M

  // NOTE: sample registers need no reset; each is written before the decision tick reads it.
  always_ff @(posedge clk) begin
    if (sample_en) begin
      if (bit_cnt_d == S_LO)  samp_q[1] <= rx_s;
      if (bit_cnt_d == S_MID) samp_q[0] <= rx_s;
    end
  end

  // NOTE: always_comb assigns a default first so no latch can be inferred.
  always_comb begin
    line_low = 1'b0;
    line_low = (!samp_q[1] && !samp_q[0]) || (!samp_q[1] && !rx_s) || (!samp_q[0] && !rx_s);
  end
`else
  logic mid_q;

  // NOTE: the mid sample needs no reset; it is written before the decision tick reads it.
  always_ff @(posedge clk) begin
    if (sample_en && (bit_cnt_d == S_MID)) mid_q <= rx_s;
  end

  // NOTE: always_comb assigns a default first so no latch can be inferred.
  always_comb begin
    line_low = 1'b0;
    line_low = !mid_q;
  end
`endif

  // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q        <= '1;
      state_q       <= IDLE_WAIT;
      idle_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      start_valid_q <= 1'b0;
      false_start_q <= 1'b0;
      false_count_q <= '0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], rx_in};
      start_valid_q <= 1'b0;
      false_start_q <= 1'b0;
      if (clr_count) false_count_q <= '0;

      case (state_q)
        IDLE_WAIT: begin
          if (frame_busy) begin
            idle_cnt_q <= '0;
          end else if (baud_tick) begin
            if (!rx_s) begin
              idle_cnt_q <= '0;
            end else if (idle_cnt_q == ARM_LAST) begin
              idle_cnt_q <= '0;
              state_q    <= ARMED;
            end else begin
              idle_cnt_q <= idle_cnt_q + IDLE_ONE;
            end
          end
        end

        ARMED: begin
          if (frame_busy) begin
            state_q <= IDLE_WAIT;
          end else if (baud_tick && !rx_s) begin
            state_q   <= CHECK;
            bit_cnt_q <= bit_cnt_d;
          end
        end

        CHECK: begin
          if (frame_busy) begin
            state_q   <= IDLE_WAIT;
            bit_cnt_q <= '0;
          end else if (baud_tick) begin
            if (bit_cnt_d == S_HI) begin
              state_q   <= IDLE_WAIT;
              bit_cnt_q <= '0;
              if (line_low) begin
                start_valid_q <= 1'b1;
              end else begin
                false_start_q <= 1'b1;
                // A coincident clear wins over the increment.
                if (!clr_count && (false_count_q != CNT_MAX))
                  false_count_q <= false_count_q + CNT_ONE;
              end
            end else begin
              bit_cnt_q <= bit_cnt_d;
            end
          end
        end

        default: begin
          state_q   <= IDLE_WAIT;
          bit_cnt_q <= '0;
        end
      endcase
    end
  end

  assign start_valid = start_valid_q;
  assign false_start = false_start_q;
  assign detecting   = (state_q == CHECK);
  assign armed       = (state_q == ARMED);
  assign false_count = false_count_q;

endmodule

// File: tb/tb_rx_start_detect.sv
// Self-checking bench for rx_start_detect: directed scenarios plus randomized line/tick traffic
// compared every cycle against a tick-level behavioural model (8-bit and 2-bit counter instances).
module tb_rx_start_detect;

  localparam int OS = 16;
  localparam int SS = 2;
  localparam int AT = 8;
  localparam int CW = 8;
  localparam int M  = OS / 2;

  logic clk = 1'b0;
  logic rst, rx_in, baud_tick, frame_busy, clr_count;
  logic sv, fs, det, arm;
  logic [CW-1:0] fc;
  logic sv2, fs2, det2, arm2;
  logic [1:0] fc2;

  always #5 clk = ~clk;

  rx_start_detect #(.OVERSAMPLE(OS), .SYNC_STAGES(SS), .ARM_TICKS(AT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .baud_tick(baud_tick), .frame_busy(frame_busy),
    .clr_count(clr_count), .start_valid(sv), .false_start(fs), .detecting(det), .armed(arm),
    .false_count(fc)
  );

  rx_start_detect #(.OVERSAMPLE(OS), .SYNC_STAGES(SS), .ARM_TICKS(AT), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .rx_in(rx_in), .baud_tick(baud_tick), .frame_busy(frame_busy),
    .clr_count(clr_count), .start_valid(sv2), .false_start(fs2), .detecting(det2), .armed(arm2),
    .false_count(fc2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: mode 0 = waiting for idle run, 1 = armed, 2 = validating a start.
  int mode, run, k, m_cnt, m_cnt2;
  bit e_sv, e_fs;
  bit samples[$];
  bit rq[$];

  // Observation bookkeeping for directed scenarios.
  int sv_seen, fs_seen, arm_seen, sv_tick, tick_idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  function automatic bit judged_low();
`ifdef RX_START_MAJORITY_EN
    int lows = 0;
    foreach (samples[i]) if (!samples[i]) lows++;
    return lows >= 2;
`else
    return samples[1] == 1'b0;
`endif
  endfunction

  task automatic note_sample(input bit v);
    if (k >= M - 1 && k <= M + 1) samples.push_back(v);
  endtask

  task automatic model_reset();
    mode = 0; run = 0; k = 0; m_cnt = 0; m_cnt2 = 0; e_sv = 0; e_fs = 0;
    samples.delete();
    rq.delete();
    for (int i = 0; i < SS; i++) rq.push_back(1'b1);
  endtask

  task automatic model_step();
    bit rxs;
    rxs = rq[0];
    e_sv = 0; e_fs = 0;
    if (rst) begin
      model_reset();
    end else begin
      if (clr_count) begin m_cnt = 0; m_cnt2 = 0; end
      case (mode)
        0: if (frame_busy) run = 0;
           else if (baud_tick) begin
             run = rxs ? run + 1 : 0;
             if (run == AT) begin mode = 1; run = 0; end
           end
        1: if (frame_busy) begin mode = 0; run = 0; end
           else if (baud_tick && !rxs) begin
             mode = 2; k = 1; samples.delete(); note_sample(rxs);
           end
        default: if (frame_busy) begin mode = 0; run = 0; end
           else if (baud_tick) begin
             k++;
             note_sample(rxs);
             if (k == M + 1) begin
               mode = 0; run = 0;
               if (judged_low()) e_sv = 1;
               else begin
                 e_fs = 1;
                 if (!clr_count) begin
                   if (m_cnt < 255) m_cnt++;
                   if (m_cnt2 < 3) m_cnt2++;
                 end
               end
             end
           end
      endcase
      void'(rq.pop_front());
      rq.push_back(rx_in);
    end
  endtask

  // One clock: model advances on the edge, outputs are compared 1 time unit later.
  task automatic cyc();
    logic [11:0] exp1, obs1;
    logic [5:0]  exp2, obs2;
    @(posedge clk);
    model_step();
    #1;
    exp1 = {e_sv, e_fs, mode == 2, mode == 1, 8'(m_cnt)};
    obs1 = {sv, fs, det, arm, fc};
    exp2 = {e_sv, e_fs, mode == 2, mode == 1, 2'(m_cnt2)};
    obs2 = {sv2, fs2, det2, arm2, fc2};
    chk("cycle_cnt8", 32'(obs1), 32'(exp1));
    chk("cycle_cnt2", 32'(obs2), 32'(exp2));
    if (sv) begin sv_seen++; sv_tick = tick_idx; end
    if (fs) fs_seen++;
    if (arm) arm_seen++;
  endtask

  // One baud period: 'gap' idle cycles then a tick cycle, line held at 'rx'.
  task automatic period(input bit rx, input bit busy, input int gap, input bit clr_on_tick);
    rx_in = rx; frame_busy = busy; baud_tick = 1'b0; clr_count = 1'b0;
    repeat (gap) cyc();
    tick_idx++;
    baud_tick = 1'b1; clr_count = clr_on_tick;
    cyc();
    baud_tick = 1'b0; clr_count = 1'b0;
  endtask

  task automatic clear_obs();
    sv_seen = 0; fs_seen = 0; arm_seen = 0; sv_tick = -1; tick_idx = 0;
  endtask

  task automatic glitch(input bit clr_at_decision);
    repeat (3) period(1'b0, 1'b0, 3, 1'b0);
    repeat (5) period(1'b1, 1'b0, 3, 1'b0);
    period(1'b1, 1'b0, 3, clr_at_decision);
    repeat (8) period(1'b1, 1'b0, 3, 1'b0);
  endtask

  initial begin
    rst = 1'b1; rx_in = 1'b1; baud_tick = 1'b0; frame_busy = 1'b0; clr_count = 1'b0;
    model_reset();
    clear_obs();
    cyc(); cyc();
    rst = 1'b0;
    chk("reset_outputs", 32'({sv, fs, det, arm, fc}), 32'd0);
    chk("reset_count2", 32'(fc2), 32'd0);

    // Clean start.
    repeat (7) period(1'b1, 1'b0, 3, 1'b0);
    chk("not_armed_after_7", 32'(arm), 32'd0);
    period(1'b1, 1'b0, 3, 1'b0);
    chk("armed_after_8", 32'(arm), 32'd1);
    clear_obs();
    repeat (16) period(1'b0, 1'b0, 3, 1'b0);
    chk("clean_sv_count", 32'(sv_seen), 32'd1);
    chk("clean_sv_tick", 32'(sv_tick), 32'(M + 1));
    chk("clean_no_false", 32'(fs_seen), 32'd0);
    chk("clean_count", 32'(fc), 32'd0);
    repeat (8) period(1'b1, 1'b0, 3, 1'b0);
    chk("rearm_after_clean", 32'(arm), 32'd1);

    // Glitch of 3 ticks.
    clear_obs();
    glitch(1'b0);
    chk("glitch_fs_count", 32'(fs_seen), 32'd1);
    chk("glitch_no_sv", 32'(sv_seen), 32'd0);
    chk("glitch_count", 32'(fc), 32'd1);
    chk("glitch_rearmed", 32'(arm), 32'd1);

    // Single high sample at tick M.
    clear_obs();
    repeat (M - 1) period(1'b0, 1'b0, 3, 1'b0);
    period(1'b1, 1'b0, 3, 1'b0);
    repeat (8) period(1'b0, 1'b0, 3, 1'b0);
`ifdef RX_START_MAJORITY_EN
    chk("dip_sv", 32'(sv_seen), 32'd1);
    chk("dip_fs", 32'(fs_seen), 32'd0);
    chk("dip_count", 32'(fc), 32'd1);
`else
    chk("dip_sv", 32'(sv_seen), 32'd0);
    chk("dip_fs", 32'(fs_seen), 32'd1);
    chk("dip_count", 32'(fc), 32'd2);
`endif
    repeat (8) period(1'b1, 1'b0, 3, 1'b0);

    // Busy blocking: enter CHECK, then busy with low pulses.
    clear_obs();
    repeat (4) period(1'b0, 1'b0, 3, 1'b0);
    chk("busy_pre_detecting", 32'(det), 32'd1);
    arm_seen = 0;
    for (int i = 0; i < 10; i++) period(i[0], 1'b1, 3, 1'b0);
    chk("busy_no_sv", 32'(sv_seen), 32'd0);
    chk("busy_no_fs", 32'(fs_seen), 32'd0);
    chk("busy_never_armed", 32'(arm_seen), 32'd0);
    repeat (7) period(1'b1, 1'b0, 3, 1'b0);
    chk("busy_release_7", 32'(arm), 32'd0);
    period(1'b1, 1'b0, 3, 1'b0);
    chk("busy_release_8", 32'(arm), 32'd1);

    // Saturation of the 2-bit counter and coincident clear.
    rx_in = 1'b1; clr_count = 1'b1; cyc(); clr_count = 1'b0;
    repeat (5) glitch(1'b0);
    chk("sat_count2", 32'(fc2), 32'd3);
    chk("sat_count8", 32'(fc), 32'd5);
    glitch(1'b1);
    chk("clr_wins_count2", 32'(fc2), 32'd0);
    chk("clr_wins_count8", 32'(fc), 32'd0);

    // Reset in the middle of CHECK.
    clear_obs();
    repeat (5) period(1'b0, 1'b0, 3, 1'b0);
    chk("midrst_detecting", 32'(det), 32'd1);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("midrst_outputs", 32'({sv, fs, det, arm, fc}), 32'd0);
    repeat (6) period(1'b0, 1'b0, 3, 1'b0);
    chk("midrst_no_sv", 32'(sv_seen), 32'd0);
    chk("midrst_no_fs", 32'(fs_seen), 32'd0);
    repeat (7) period(1'b1, 1'b0, 3, 1'b0);
    chk("midrst_arm_7", 32'(arm), 32'd0);
    period(1'b1, 1'b0, 3, 1'b0);
    chk("midrst_arm_8", 32'(arm), 32'd1);

    // Randomized traffic: line runs of random level/length, random tick spacing, busy and clear.
    for (int s = 0; s < 400; s++) begin
      bit lvl, busy;
      int len;
      lvl  = ($urandom_range(0, 9) < 6);
      len  = $urandom_range(1, 20);
      busy = ($urandom_range(0, 19) == 0);
      for (int t = 0; t < len; t++)
        period(lvl, busy, $urandom_range(0, 3), ($urandom_range(0, 29) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
